// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: iterative multiply/divide sequencer that owns the HI/LO
// registers. It runs beside the EX-stage ALU and retires one product or
// quotient bit per clock. MULT/MULTU use shift-add and DIV/DIVU use restoring
// division. Signed operands are reduced to magnitudes on issue and the sign is
// restored in a single FIX cycle.
module muldiv_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             hilo_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_req
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] operand;

  logic             signed_op;
  logic             opa_neg;
  logic             opb_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]   mult_sum;
  logic [WIDTH-1:0] mult_next_hi;
  logic [WIDTH-1:0] mult_next_lo;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_next_hi;
  logic [WIDTH-1:0] div_next_lo;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Operand conditioning: op[0] clear means signed, so magnitudes are taken.
  assign signed_op = ~op[0];
  assign opa_neg   = signed_op & opa[WIDTH-1];
  assign opb_neg   = signed_op & opb[WIDTH-1];
  assign abs_a     = opa_neg ? -opa : opa;
  assign abs_b     = opb_neg ? -opb : opb;

  // Shift-add step: {acc_hi, acc_lo} is the partial product. The multiplier
  // drains out of acc_lo from its LSB end.
  assign mult_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
  assign mult_next_hi = mult_sum[WIDTH:1];
  assign mult_next_lo = {mult_sum[0], acc_lo[WIDTH-1:1]};

  // Restoring step: acc_hi is the remainder. acc_lo shifts the dividend out
  // at the top and the quotient bits in at the bottom.
  assign div_shift   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff    = div_shift - {1'b0, operand};
  assign div_ok      = ~div_diff[WIDTH];
  assign div_next_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next_lo = {acc_lo[WIDTH-2:0], div_ok};

  // Sign fixup. The remainder follows the dividend, so -|a| returns the raw
  // opa on a divide by zero. The quotient is forced to all ones in that case.
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = (sign_a ^ sign_b) ? -prod : prod;
  assign quo_fix  = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
  assign rem_fix  = sign_a ? -acc_hi : acc_hi;
  assign fix_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = is_div ? (div_zero ? {WIDTH{1'b1}} : quo_fix) : prod_fix[WIDTH-1:0];

  assign busy      = (state != IDLE);
  assign stall_req = busy & (hilo_read | start | mthi | mtlo);

  // State register; an asynchronous reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A cancel wins over both issue and completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (count == CW'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Iteration datapath: capture the operands on issue, then take one step per clock in CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            count    <= '0;
            is_div   <= op[1];
            sign_a   <= opa_neg;
            sign_b   <= opb_neg;
            div_zero <= (opb == '0);
            acc_hi   <= '0;
            acc_lo   <= op[1] ? abs_a : abs_b;
            operand  <= op[1] ? abs_b : abs_a;
          end
        end
        CALC: begin
          if (!cancel) begin
            count  <= count + CW'(1);
            acc_hi <= is_div ? div_next_hi : mult_next_hi;
            acc_lo <= is_div ? div_next_lo : mult_next_lo;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // HI/LO storage. A completed operation writes both registers. Moves from
  // the register file are taken only in an idle cycle with no issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX && !cancel) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else if (state == IDLE && !start) begin
      if (mthi) begin
        hi <= opa;
      end
      if (mtlo) begin
        lo <= opa;
      end
    end
  end

  // Completion pulse: high for the one cycle after HI/LO take a result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == FIX) && !cancel;
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb_muldiv_seq_unit: scoreboard bench for muldiv_seq_unit. Expected HI/LO
// pairs are queued at issue and retired on each done pulse.
module tb_muldiv_seq_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cancel;
  logic             mthi;
  logic             mtlo;
  logic             hilo_read;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall_req;

  int checks = 0;
  int errors = 0;

  logic [63:0]      exp_q[$];
  logic [WIDTH-1:0] model_hi = '0;
  logic [WIDTH-1:0] model_lo = '0;

  muldiv_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .cancel    (cancel),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .hilo_read (hilo_read),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall_req (stall_req)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference arithmetic: returns {HI, LO} for one operation.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      p;
    logic [31:0] q;
    logic [31:0] rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      2'd0: begin
        p = sa * sb;
        r = p;
      end
      2'd1: r = {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 0) begin
          r = {a, 32'hFFFF_FFFF};
        end else begin
          q  = 32'(sa / sb);
          rm = 32'(sa % sb);
          r  = {rm, q};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Scoreboard: every done pulse retires the oldest queued expectation.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("hi", 64'(hi), 64'(e[63:32]));
        checkOutput("lo", 64'(lo), 64'(e[31:0]));
        model_hi = e[63:32];
        model_lo = e[31:0];
      end
    end
  end

  // Issue one operation for a single edge (E0); returns in the cycle after E0.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    op    = o;
    opa   = a;
    opb   = b;
    start = 1'b1;
    if (expect_result) exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Bounded wait for done; checks latency, busy release and pulse width.
  task automatic waitDone();
    int k;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    checkOutput("latency", 64'(k), 64'(WIDTH + 1));
    checkOutput("busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("done_pulse_width", 64'(done), 64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    logic [WIDTH-1:0] prev_hi;
    logic [WIDTH-1:0] prev_lo;
    logic [1:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    int               pulses;

    rst = 1'b1;
    start = 1'b0;
    op = 2'd0;
    opa = '0;
    opb = '0;
    cancel = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    hilo_read = 1'b0;

    @(negedge clk);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed arithmetic");
    applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    waitDone();
    checkOutput("multu_max_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    checkOutput("multu_max_lo", 64'(lo), 64'h0000_0000_0000_0001);
    applyStimulus(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
    waitDone();
    applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    waitDone();
    applyStimulus(2'd3, 32'd100, 32'd0, 1'b1);
    waitDone();
    applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitDone();
    checkOutput("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
    applyStimulus(2'd2, 32'hFFFF_FF9C, 32'd0, 1'b1);
    waitDone();
    applyStimulus(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    waitDone();

    $display("[TB] random arithmetic");
    for (int i = 0; i < 6; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      applyStimulus(r_op, r_a, r_b, 1'b1);
      waitDone();
    end

    $display("[TB] moves to HI/LO");
    opa  = 32'h0000_ABCD;
    mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    checkOutput("mtlo_lo", 64'(lo), 64'h0000_0000_0000_ABCD);
    checkOutput("mtlo_hi_kept", 64'(hi), 64'(model_hi));
    model_lo = 32'h0000_ABCD;
    opa  = 32'h0000_1234;
    mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    checkOutput("mthi_hi", 64'(hi), 64'h0000_0000_0000_1234);
    model_hi = 32'h0000_1234;

    mthi = 1'b1;
    applyStimulus(2'd1, 32'h5555, 32'd3, 1'b1);
    mthi = 1'b0;
    checkOutput("mthi_with_start", 64'(hi), 64'(model_hi));
    waitDone();

    $display("[TB] stall and ignored second start");
    applyStimulus(2'd0, 32'd5, 32'd5, 1'b1);
    for (int k = 0; k <= 34; k++) begin
      if (k > 0) @(negedge clk);
      hilo_read = (k >= 4);
      if (k == 9) begin
        start = 1'b1;
        op    = 2'd1;
        opa   = 32'd77;
        opb   = 32'd9;
      end
      if (k == 10) start = 1'b0;
      #1;
      checkOutput("stall_req", 64'(stall_req), 64'((k >= 4) && (k <= 32)));
    end
    hilo_read = 1'b0;
    checkOutput("stall_hi", 64'(hi), 64'd0);
    checkOutput("stall_lo", 64'(lo), 64'd25);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);

    $display("[TB] cancel mid-op");
    prev_hi = model_hi;
    prev_lo = model_lo;
    applyStimulus(2'd0, 32'h1234, 32'h5678, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 5) begin
        mtlo = 1'b1;
        opa  = 32'hDEAD;
      end
      if (k == 6) mtlo = 1'b0;
      if (k == 11) cancel = 1'b1;
    end
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel_idle", 64'(busy), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("cancel_no_done", 64'(pulses), 64'd0);
    checkOutput("cancel_hi_kept", 64'(hi), 64'(prev_hi));
    checkOutput("cancel_lo_kept", 64'(lo), 64'(prev_lo));

    $display("[TB] async reset mid-divide");
    applyStimulus(2'd2, 32'd1000, 32'd7, 1'b0);
    repeat (19) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(2'd3, 32'd50, 32'd7, 1'b1);
    waitDone();
    checkOutput("final_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
